// File: rtl/sdram_req_pkg.sv
// Shared types and constants for the SDRAM request master (sdram_req_master).
package sdram_req_pkg;

  localparam int unsigned SDRAM_AW = 25;
  localparam int unsigned SDRAM_DW = 16;
  localparam int unsigned CLIENTS  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic                we;
    logic [SDRAM_AW-1:0] addr;
    logic [SDRAM_DW-1:0] din;
    logic [1:0]          ds;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_if.sv
// Bus bundle between the two chipset clients, the request master and the sdram word port.
interface sdram_req_if
  import sdram_req_pkg::*;
#(
  parameter int unsigned AW = SDRAM_AW,
  parameter int unsigned DW = SDRAM_DW
);

  logic          cep;

  logic          c0_req;
  logic          c0_we;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_din;
  logic [1:0]    c0_ds;
  logic          c0_ack;
  logic [DW-1:0] c0_dout;

  logic          c1_req;
  logic          c1_we;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_din;
  logic [1:0]    c1_ds;
  logic          c1_ack;
  logic [DW-1:0] c1_dout;

  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_din;
  logic [1:0]    sdram_ds;
  logic          sdram_we;
  logic          sdram_oe;
  logic [DW-1:0] sdram_out;

  modport master (
    input  cep,
    input  c0_req, c0_we, c0_addr, c0_din, c0_ds,
    output c0_ack, c0_dout,
    input  c1_req, c1_we, c1_addr, c1_din, c1_ds,
    output c1_ack, c1_dout,
    output sdram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe,
    input  sdram_out
  );

  modport slave (
    output cep,
    output c0_req, c0_we, c0_addr, c0_din, c0_ds,
    input  c0_ack, c0_dout,
    output c1_req, c1_we, c1_addr, c1_din, c1_ds,
    input  c1_ack, c1_dout,
    input  sdram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe,
    output sdram_out
  );

endinterface

// File: rtl/sdram_req_arb.sv
// Combinational two-client grant. SDRAM_REQ_RR_EN selects round-robin ties, else fixed c0 priority.
module sdram_req_arb
  import sdram_req_pkg::*;
(
  input  logic [CLIENTS-1:0] req_i,
`ifdef SDRAM_REQ_RR_EN
  input  logic               last_i,
`endif
  output logic               gnt_valid_o,
  output logic               gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = req_i[1] & ~req_i[0];
    if (&req_i) begin
`ifdef SDRAM_REQ_RR_EN
      gnt_idx_o = ~last_i;
`else
      gnt_idx_o = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/sdram_req_master.sv
// Arbitrates two clients onto the cep-slotted sdram word port, one access per slot.
// SDRAM_REQ_RR_EN: round-robin tie-break (default build: fixed c0 priority).
module sdram_req_master
  import sdram_req_pkg::*;
#(
  parameter int unsigned AW     = SDRAM_AW,
  parameter int unsigned DW     = SDRAM_DW,
  parameter int unsigned RD_LAT = 4
) (
  input logic         clk_sys,
  input logic         RESET,
  sdram_req_if.master bus
);

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t             state_q;
  sdram_req_t         req_q;
  logic               we_q;
  logic               oe_q;
  logic               gnt_q;
  logic [3:0]         cnt_q;
  logic [CLIENTS-1:0] ack_q;
  logic [DW-1:0]      dout0_q;
  logic [DW-1:0]      dout1_q;

  logic [CLIENTS-1:0] req_vec;
  logic               gnt_valid;
  logic               gnt_idx;
  sdram_req_t         cand0;
  sdram_req_t         cand1;
  sdram_req_t         win;

  assign req_vec = {bus.c1_req, bus.c0_req};
  assign cand0   = '{we: bus.c0_we, addr: SDRAM_AW'(bus.c0_addr),
                     din: SDRAM_DW'(bus.c0_din), ds: bus.c0_ds};
  assign cand1   = '{we: bus.c1_we, addr: SDRAM_AW'(bus.c1_addr),
                     din: SDRAM_DW'(bus.c1_din), ds: bus.c1_ds};
  assign win     = gnt_idx ? cand1 : cand0;

`ifdef SDRAM_REQ_RR_EN
  logic last_q;

  sdram_req_arb u_arb (
    .req_i       (req_vec),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );
`else
  sdram_req_arb u_arb (
    .req_i       (req_vec),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );
`endif

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
`ifdef SDRAM_REQ_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            req_q   <= win;
            we_q    <= win.we;
            oe_q    <= ~win.we;
            gnt_q   <= gnt_idx;
`ifdef SDRAM_REQ_RR_EN
            last_q  <= gnt_idx;
`endif
            state_q <= ISSUE;
          end else begin
            we_q <= 1'b0;
            oe_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.cep) begin
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            // Writes spend one WAIT cycle so their ack lands two cycles after the sampling cep.
            cnt_q   <= req_q.we ? 4'd0 : CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (!req_q.we) begin
              if (gnt_q) dout1_q <= bus.sdram_out;
              else       dout0_q <= bus.sdram_out;
            end
            ack_q[gnt_q] <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sdram_addr = req_q.addr[AW-1:0];
  assign bus.sdram_din  = req_q.din[DW-1:0];
  assign bus.sdram_ds   = req_q.ds;
  assign bus.sdram_we   = we_q;
  assign bus.sdram_oe   = oe_q;
  assign bus.c0_ack     = ack_q[0];
  assign bus.c1_ack     = ack_q[1];
  assign bus.c0_dout    = dout0_q;
  assign bus.c1_dout    = dout1_q;

endmodule

// File: tb/tb_sdram_req_master.sv
// Directed bench for sdram_req_master: RD_LAT=4 instance with cep every 8 cycles,
// RD_LAT=1 instance with cep held high.
module tb_sdram_req_master;

  localparam int unsigned RL4 = 4;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  sdram_req_if #(.AW(25), .DW(16)) bus4 ();
  sdram_req_if #(.AW(25), .DW(16)) bus1 ();

  sdram_req_master #(.AW(25), .DW(16), .RD_LAT(RL4)) dut4 (
    .clk_sys (clk),
    .RESET   (RESET),
    .bus     (bus4.master)
  );

  sdram_req_master #(.AW(25), .DW(16), .RD_LAT(1)) dut1 (
    .clk_sys (clk),
    .RESET   (RESET),
    .bus     (bus1.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit excl_bad = 1'b0;

  // Controller model: data for an address, returned RD_LAT cycles after the sampling cep.
  function automatic logic [15:0] mem_data(input logic [24:0] a);
    if (a == 25'h1FFFFFF) return 16'h1234;
    return a[15:0] ^ 16'hC3C3;
  endfunction

  logic        pv4 [RL4];
  logic [15:0] pd4 [RL4];
  logic        pv1;
  logic [15:0] pd1;

  always @(posedge clk) begin
    pv4[0] <= bus4.cep && bus4.sdram_oe;
    pd4[0] <= mem_data(bus4.sdram_addr);
    for (int i = 1; i < RL4; i++) begin
      pv4[i] <= pv4[i-1];
      pd4[i] <= pd4[i-1];
    end
    pv1 <= bus1.cep && bus1.sdram_oe;
    pd1 <= mem_data(bus1.sdram_addr);
  end

  assign bus4.sdram_out = pv4[RL4-1] ? pd4[RL4-1] : 16'hDEAD;
  assign bus1.sdram_out = pv1 ? pd1 : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cep_at(input int t);
    return (t % 8) == 0;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    bus4.cep = cep_at(cyc);
    if ((bus4.sdram_we && bus4.sdram_oe) || (bus1.sdram_we && bus1.sdram_oe)) excl_bad = 1'b1;
  endtask

  task automatic drive4(input logic cl, input logic req, input logic we,
                        input logic [24:0] addr, input logic [15:0] din, input logic [1:0] ds);
    if (cl) begin
      bus4.c1_req = req; bus4.c1_we = we; bus4.c1_addr = addr; bus4.c1_din = din; bus4.c1_ds = ds;
    end else begin
      bus4.c0_req = req; bus4.c0_we = we; bus4.c0_addr = addr; bus4.c0_din = din; bus4.c0_ds = ds;
    end
  endtask

  typedef struct {
    logic        cl;
    logic        we;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    logic [15:0] exp_dout;
    bit          align;
  } vec_t;

  vec_t vecs [7];

  // One access on the RD_LAT=4 port. Sampling tick and ack tick are predicted from the cep schedule.
  task automatic run_access(input vec_t v, input int tag);
    int t0;
    int ts;
    int tack;
    bit hold_ok  = 1'b1;
    bit clr_ok   = 1'b1;
    bit ack_ok   = 1'b1;
    bit other_ok = 1'b1;
    logic [15:0] dseen = 16'h0;
    logic ack_me;
    logic ack_other;
    if (v.align)
      for (int i = 0; i < 8 && !cep_at(cyc); i++) tick();
    drive4(v.cl, 1'b1, v.we, v.addr, v.din, v.ds);
    t0 = cyc;
    ts = t0 + 1;
    while (!cep_at(ts)) ts++;
    tack = ts + (v.we ? 2 : RL4 + 1);
    while (cyc < tack + 1) begin
      tick();
      ack_me    = v.cl ? bus4.c1_ack : bus4.c0_ack;
      ack_other = v.cl ? bus4.c0_ack : bus4.c1_ack;
      if (cyc <= ts) begin
        if (bus4.sdram_we !== v.we || bus4.sdram_oe !== !v.we || bus4.sdram_addr !== v.addr ||
            bus4.sdram_din !== v.din || bus4.sdram_ds !== v.ds) hold_ok = 1'b0;
      end else if (bus4.sdram_we !== 1'b0 || bus4.sdram_oe !== 1'b0) begin
        clr_ok = 1'b0;
      end
      if (ack_me !== (cyc == tack)) ack_ok = 1'b0;
      if (ack_other !== 1'b0) other_ok = 1'b0;
      if (cyc == tack) begin
        dseen = v.cl ? bus4.c1_dout : bus4.c0_dout;
        drive4(v.cl, 1'b0, v.we, v.addr, v.din, v.ds);
      end
    end
    check($sformatf("v%0d_bus_held_until_cep", tag), {31'b0, hold_ok}, 32'd1);
    check($sformatf("v%0d_strobe_cleared", tag), {31'b0, clr_ok}, 32'd1);
    check($sformatf("v%0d_ack_timing", tag), {31'b0, ack_ok}, 32'd1);
    check($sformatf("v%0d_other_ack_quiet", tag), {31'b0, other_ok}, 32'd1);
    if (!v.we) check($sformatf("v%0d_dout", tag), {16'b0, dseen}, {16'b0, v.exp_dout});
  endtask

  initial begin : main
    int order [$];
    int exp_ord [4];
    bit both_ack;
    bit extra_ack;
    int t0;
    int ts;
    int prev;
    int k;
    logic [24:0] a6 [4];
    logic [15:0] e6 [4];

    vecs[0] = '{cl: 1'b0, we: 1'b1, addr: 25'h0000100, din: 16'hA55A, ds: 2'b11, exp_dout: 16'h0,    align: 1'b0};
    vecs[1] = '{cl: 1'b1, we: 1'b0, addr: 25'h1FFFFFF, din: 16'h0000, ds: 2'b11, exp_dout: 16'h1234, align: 1'b0};
    vecs[2] = '{cl: 1'b1, we: 1'b1, addr: 25'h00ABCDE, din: 16'h0F0F, ds: 2'b01, exp_dout: 16'h0,    align: 1'b0};
    vecs[3] = '{cl: 1'b0, we: 1'b0, addr: 25'h0000042, din: 16'h1111, ds: 2'b11, exp_dout: 16'hC381, align: 1'b0};
    vecs[4] = '{cl: 1'b0, we: 1'b1, addr: 25'h1555555, din: 16'hFFFF, ds: 2'b10, exp_dout: 16'h0,    align: 1'b1};
    vecs[5] = '{cl: 1'b1, we: 1'b0, addr: 25'h0002468, din: 16'h0000, ds: 2'b11, exp_dout: 16'hE7AB, align: 1'b1};
    vecs[6] = '{cl: 1'b1, we: 1'b0, addr: 25'h0000300, din: 16'h0000, ds: 2'b11, exp_dout: 16'hC0C3, align: 1'b0};

    a6 = '{25'h0000011, 25'h0000022, 25'h1FFFFFF, 25'h0000ABC};
    e6 = '{16'hC3D2, 16'hC3E1, 16'h1234, 16'hC97F};

`ifdef SDRAM_REQ_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif

    RESET = 1'b1;
    bus4.cep = 1'b0;
    bus1.cep = 1'b1;
    drive4(1'b0, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
    drive4(1'b1, 1'b0, 1'b0, 25'h0, 16'h0, 2'b00);
    bus1.c0_req = 1'b0; bus1.c0_we = 1'b0; bus1.c0_addr = '0; bus1.c0_din = '0; bus1.c0_ds = 2'b11;
    bus1.c1_req = 1'b0; bus1.c1_we = 1'b0; bus1.c1_addr = '0; bus1.c1_din = '0; bus1.c1_ds = 2'b00;
    repeat (3) tick();

    check("rst_we_oe", {30'b0, bus4.sdram_we, bus4.sdram_oe}, 32'd0);
    check("rst_addr", {7'b0, bus4.sdram_addr}, 32'd0);
    check("rst_din_ds", {14'b0, bus4.sdram_din, bus4.sdram_ds}, 32'd0);
    check("rst_acks", {28'b0, bus4.c0_ack, bus4.c1_ack, bus1.c0_ack, bus1.c1_ack}, 32'd0);
    check("rst_douts", {bus4.c0_dout, bus4.c1_dout}, 32'd0);
    RESET = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i], i);
      tick();
    end

    // Both clients held high for four consecutive accesses.
    both_ack = 1'b0;
    drive4(1'b0, 1'b1, 1'b0, 25'h0000010, 16'h0000, 2'b11);
    drive4(1'b1, 1'b1, 1'b1, 25'h0000020, 16'hBEEF, 2'b11);
    for (int i = 0; i < 300 && order.size() < 4; i++) begin
      tick();
      if (bus4.c0_ack && bus4.c1_ack) both_ack = 1'b1;
      else if (bus4.c0_ack) order.push_back(0);
      else if (bus4.c1_ack) order.push_back(1);
    end
    drive4(1'b0, 1'b0, 1'b0, 25'h0000010, 16'h0000, 2'b11);
    drive4(1'b1, 1'b0, 1'b1, 25'h0000020, 16'hBEEF, 2'b11);
    extra_ack = 1'b0;
    repeat (20) begin
      tick();
      if (bus4.c0_ack || bus4.c1_ack) extra_ack = 1'b1;
    end
    check("tie_ack_count", order.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("tie_order%0d", i), (i < order.size()) ? order[i] : 32'hFF, exp_ord[i]);
    check("tie_no_double_ack", {31'b0, both_ack}, 32'd0);
    check("tie_no_extra_ack", {31'b0, extra_ack}, 32'd0);

    // Reset while the read waits for data.
    drive4(1'b0, 1'b1, 1'b0, 25'h0000077, 16'h0000, 2'b11);
    t0 = cyc;
    ts = t0 + 1;
    while (!cep_at(ts)) ts++;
    while (cyc < ts + 2) tick();
    check("rstmid_addr_before", {7'b0, bus4.sdram_addr}, 32'h77);
    #1 RESET = 1'b1;
    #1;
    check("rstmid_we_oe", {30'b0, bus4.sdram_we, bus4.sdram_oe}, 32'd0);
    check("rstmid_ack", {30'b0, bus4.c0_ack, bus4.c1_ack}, 32'd0);
    check("rstmid_addr_async", {7'b0, bus4.sdram_addr}, 32'd0);
    drive4(1'b0, 1'b0, 1'b0, 25'h0000077, 16'h0000, 2'b11);
    tick();
    RESET = 1'b0;
    extra_ack = 1'b0;
    repeat (12) begin
      tick();
      if (bus4.c0_ack || bus4.c1_ack) extra_ack = 1'b1;
    end
    check("rstmid_no_ack_after", {31'b0, extra_ack}, 32'd0);
    run_access(vecs[6], 6);
    tick();

    // Back-to-back reads with cep every cycle and RD_LAT=1.
    bus1.c0_addr = a6[0];
    bus1.c0_req  = 1'b1;
    t0   = cyc;
    prev = 0;
    k    = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      tick();
      if (bus1.c0_ack) begin
        check($sformatf("b2b_dout%0d", k), {16'b0, bus1.c0_dout}, {16'b0, e6[k]});
        if (k == 0) check("b2b_first_latency", cyc - t0, 32'd3);
        else        check($sformatf("b2b_interval%0d", k), cyc - prev, 32'd4);
        prev = cyc;
        k++;
        if (k < 4) bus1.c0_addr = a6[k];
        else       bus1.c0_req = 1'b0;
      end
    end
    check("b2b_ack_count", k, 32'd4);
    check("b2b_c1_ack_quiet", {31'b0, bus1.c1_ack}, 32'd0);
    repeat (4) tick();
    check("we_oe_exclusive", {31'b0, excl_bad}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
